signed_serial_divider: RTL and testbench

//  Bit-serial signed integer divider for the PE datapath; the inverse of the bit-serial signed multiplier.

---
 rtl/signed_serial_divider_pkg.sv | 20 ++
 rtl/signed_serial_divider_div_sub_step.sv | 18 +
 rtl/signed_serial_divider.sv | 135 +++++++++++++
 tb/tb_signed_serial_divider.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/signed_serial_divider_pkg.sv
// Shared types and helpers for the bit-serial signed divider.
package signed_serial_divider_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/signed_serial_divider_div_sub_step.sv
// One restoring-division step: trial subtract of the divisor magnitude from the partial remainder.
module signed_serial_divider_div_sub_step #(
   parameter int unsigned BITWIDTH = 8
) (
   input  logic [BITWIDTH:0]   partial,
   input  logic [BITWIDTH-1:0] divisor,
   output logic [BITWIDTH:0]   next_partial,
   output logic                q_bit
);

   logic [BITWIDTH+1:0] sum;

   // partial + ~divisor + 1; carry out set means partial >= divisor
   assign sum          = {1'b0, partial} + {1'b0, ~{1'b0, divisor}} + (BITWIDTH + 2)'(1);
   assign q_bit        = sum[BITWIDTH+1];
   assign next_partial = q_bit ? sum[BITWIDTH:0] : partial;

endmodule

// File: rtl/signed_serial_divider.sv
// Bit-serial signed truncating divider: one quotient bit per clock, sign fix-up, registered outputs.
module signed_serial_divider
   import signed_serial_divider_pkg::*;
#(
   parameter int unsigned BITWIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                data_in_valid,
   output logic                in_ready,
   input  logic [BITWIDTH-1:0] dividend,
   input  logic [BITWIDTH-1:0] divisor,
   output logic                data_out_valid,
   output logic [BITWIDTH-1:0] quotient,
   output logic [BITWIDTH-1:0] remainder,
   output logic                div_by_zero,
   output logic                overflow
);

   localparam int unsigned CW = clog2(BITWIDTH) + 1;
   localparam logic [BITWIDTH-1:0] MIN_VAL = {1'b1, {(BITWIDTH - 1){1'b0}}};
   localparam logic [BITWIDTH-1:0] MAX_VAL = ~MIN_VAL;
   localparam logic [BITWIDTH-1:0] ONE     = BITWIDTH'(1);
   localparam logic [BITWIDTH:0]   P_ONE   = (BITWIDTH + 1)'(1);

   state_t state_q, state_d;

   logic [BITWIDTH-1:0] dvd_q, dvs_q, quo_q;
   logic [BITWIDTH:0]   prem_q;
   logic [CW-1:0]       cnt_q;
   logic                neg_dvd_q, neg_quo_q, dbz_q, ovf_q;

   logic                valid_q, dbz_out_q, ovf_out_q;
   logic [BITWIDTH-1:0] quo_out_q, rem_out_q;

   logic                accept;
   logic [BITWIDTH-1:0] dividend_mag, divisor_mag, quo_fix, rem_fix;
   logic [BITWIDTH:0]   step_rem;
   logic                step_bit;

   assign in_ready     = (state_q == S_IDLE) || (state_q == S_DONE);
   assign accept       = data_in_valid && in_ready;
   // |MIN| wraps to the MIN pattern, which is 2^(BW-1) read as unsigned
   assign dividend_mag = dividend[BITWIDTH-1] ? (~dividend + ONE) : dividend;
   assign divisor_mag  = divisor[BITWIDTH-1] ? (~divisor + ONE) : divisor;

   signed_serial_divider_div_sub_step #(
      .BITWIDTH (BITWIDTH)
   ) u_step (
      .partial      ({prem_q[BITWIDTH-1:0], dvd_q[BITWIDTH-1]}),
      .divisor      (dvs_q),
      .next_partial (step_rem),
      .q_bit        (step_bit)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_CALC;
         S_CALC:  if (cnt_q == '0) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = accept ? S_CALC : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      quo_fix = neg_quo_q ? (~quo_q + ONE) : quo_q;
      rem_fix = BITWIDTH'(neg_dvd_q ? (~prem_q + P_ONE) : prem_q);
      if (dbz_q) begin
         quo_fix = '1;
      end else if (ovf_q) begin
         quo_fix = MAX_VAL;
         rem_fix = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         dvd_q     <= '0;
         dvs_q     <= '0;
         quo_q     <= '0;
         prem_q    <= '0;
         cnt_q     <= '0;
         neg_dvd_q <= 1'b0;
         neg_quo_q <= 1'b0;
         dbz_q     <= 1'b0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
         quo_out_q <= '0;
         rem_out_q <= '0;
         dbz_out_q <= 1'b0;
         ovf_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            dvd_q     <= dividend_mag;
            dvs_q     <= divisor_mag;
            quo_q     <= '0;
            prem_q    <= '0;
            cnt_q     <= CW'(BITWIDTH - 1);
            neg_dvd_q <= dividend[BITWIDTH-1];
            neg_quo_q <= dividend[BITWIDTH-1] ^ divisor[BITWIDTH-1];
            dbz_q     <= (divisor == '0);
            ovf_q     <= (dividend == MIN_VAL) && (divisor == '1);
         end else if (state_q == S_CALC) begin
            prem_q <= step_rem;
            dvd_q  <= {dvd_q[BITWIDTH-2:0], 1'b0};
            quo_q  <= {quo_q[BITWIDTH-2:0], step_bit};
            cnt_q  <= cnt_q - CW'(1);
         end
         // Result registers hold a value only for the single DONE cycle
         valid_q <= (state_q == S_FIX);
         if (state_q == S_FIX) begin
            quo_out_q <= quo_fix;
            rem_out_q <= rem_fix;
            dbz_out_q <= dbz_q;
            ovf_out_q <= ovf_q;
         end else begin
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_out_q <= 1'b0;
            ovf_out_q <= 1'b0;
         end
      end
   end

   assign data_out_valid = valid_q;
   assign quotient       = quo_out_q;
   assign remainder      = rem_out_q;
   assign div_by_zero    = dbz_out_q;
   assign overflow       = ovf_out_q;

endmodule

// File: tb/tb_signed_serial_divider.sv
// Self-checking bench for signed_serial_divider (BITWIDTH=8) against an arithmetic reference model.
module tb_signed_serial_divider;

   localparam int BW      = 8;
   localparam int LATENCY = BW + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          data_in_valid;
   logic          in_ready;
   logic [BW-1:0] dividend;
   logic [BW-1:0] divisor;
   logic          data_out_valid;
   logic [BW-1:0] quotient;
   logic [BW-1:0] remainder;
   logic          div_by_zero;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   signed_serial_divider #(
      .BITWIDTH (BW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in_valid  (data_in_valid),
      .in_ready       (in_ready),
      .dividend       (dividend),
      .divisor        (divisor),
      .data_out_valid (data_out_valid),
      .quotient       (quotient),
      .remainder      (remainder),
      .div_by_zero    (div_by_zero),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Truncating division straight from the language operators, plus the two special cases
   function automatic void model(input logic [BW-1:0] a8, input logic [BW-1:0] b8,
                                 output logic [BW-1:0] q8, output logic [BW-1:0] r8,
                                 output logic dz, output logic ov);
      int a, b;
      a  = int'($signed(a8));
      b  = int'($signed(b8));
      dz = 1'b0;
      ov = 1'b0;
      if (b == 0) begin
         q8 = 8'hFF;
         r8 = a8;
         dz = 1'b1;
      end else if (a == -128 && b == -1) begin
         q8 = 8'h7F;
         r8 = 8'h00;
         ov = 1'b1;
      end else begin
         q8 = 8'(a / b);
         r8 = 8'(a % b);
      end
   endfunction

   task automatic run_op(input logic [BW-1:0] a, input logic [BW-1:0] b, input string tag);
      logic [BW-1:0] eq, er;
      logic          ed, eo;
      int            cyc;
      model(a, b, eq, er, ed, eo);
      @(negedge clk);
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      dividend      = a;
      divisor       = b;
      data_in_valid = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
      dividend      = 8'($urandom);
      divisor       = 8'($urandom);
      cyc           = 1;
      while (data_out_valid !== 1'b1 && cyc < 4 * LATENCY) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'(LATENCY));
      check({tag, " quotient"}, 32'(quotient), 32'(eq));
      check({tag, " remainder"}, 32'(remainder), 32'(er));
      check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ed));
      check({tag, " overflow"}, 32'(overflow), 32'(eo));
      @(negedge clk);
      check({tag, " pulse width"}, 32'(data_out_valid), 32'd0);
      check({tag, " idle outputs"}, {16'd0, quotient, remainder}, 32'd0);
   endtask

   initial begin
      logic [BW-1:0] a, b, eq, er;
      logic          ed, eo;
      logic [2*BW+1:0] exp_q[$];
      logic [2*BW+1:0] e;
      int nacc, npulse, last, pulses;

      rst           = 1'b1;
      data_in_valid = 1'b0;
      dividend      = '0;
      divisor       = '0;
      #1;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset valid", 32'(data_out_valid), 32'd0);
      check("reset results", {16'd0, quotient, remainder}, 32'd0);
      check("reset flags", {30'd0, div_by_zero, overflow}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op(8'd100, 8'd7, "100/7");
      run_op(-8'sd100, 8'd7, "-100/7");
      run_op(8'd100, -8'sd7, "100/-7");
      run_op(-8'sd100, -8'sd7, "-100/-7");
      run_op(8'h80, 8'hFF, "min/-1");
      run_op(8'h80, 8'd1, "min/1");
      run_op(8'd5, 8'd0, "5/0");
      run_op(8'hFB, 8'd0, "-5/0");
      run_op(8'd7, 8'd100, "7/100");
      run_op(8'd0, 8'hFD, "0/-3");
      run_op(8'h80, 8'h80, "min/min");

      for (int i = 0; i < 24; i++) begin
         a = 8'($urandom);
         b = (i % 3 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
         run_op(a, b, "random");
      end

      // Hold data_in_valid high and change operands every cycle; only IDLE/DONE accepts count
      nacc   = 0;
      npulse = 0;
      last   = 0;
      for (int c = 0; c < 8 * LATENCY; c++) begin
         @(negedge clk);
         if (data_out_valid) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            check("stream result", 32'({div_by_zero, overflow, quotient, remainder}), 32'(e));
            if (npulse > 0) check("stream spacing", 32'(c - last), 32'(LATENCY));
            last = c;
            npulse++;
         end
         if (nacc < 3) begin
            a             = 8'($urandom);
            b             = 8'($urandom);
            dividend      = a;
            divisor       = b;
            data_in_valid = 1'b1;
            if (in_ready) begin
               model(a, b, eq, er, ed, eo);
               exp_q.push_back({ed, eo, eq, er});
               nacc++;
            end
         end else begin
            data_in_valid = 1'b0;
         end
      end
      check("stream pulses", 32'(npulse), 32'd3);
      check("stream leftover", 32'(exp_q.size()), 32'd0);

      // Reset in the fourth CALC cycle discards the operation
      @(negedge clk);
      dividend      = 8'd100;
      divisor       = 8'd7;
      data_in_valid = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pre-reset busy", 32'(in_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("mid reset in_ready", 32'(in_ready), 32'd1);
      check("mid reset valid", 32'(data_out_valid), 32'd0);
      check("mid reset results", {16'd0, quotient, remainder}, 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      pulses = 0;
      repeat (2 * LATENCY) begin
         @(negedge clk);
         if (data_out_valid) pulses++;
      end
      check("no stale pulse", 32'(pulses), 32'd0);
      run_op(8'd9, 8'd3, "9/3 after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
